// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the register-store bus arbiter: address map,
// FSM encoding and the legality check applied before a bus cycle starts.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [31:0] CSR_BASE  = 32'hffff_8000;
    localparam logic [31:0] CSR_LIMIT = 32'hffff_bffc;
    localparam logic [31:0] GPR_BASE  = 32'hffff_c000;
    localparam logic [31:0] GPR_LIMIT = 32'hffff_c07c;
    localparam logic [31:0] TMP_BASE  = 32'hffff_c080;
    localparam logic [31:0] TMP_LIMIT = 32'hffff_c0fc;
    localparam logic [31:0] CON_BASE  = 32'hffff_c100;
    localparam logic [31:0] CON_LIMIT = 32'hffff_c1fc;
    localparam logic [31:0] RZ_ADDR   = 32'hffff_c200;
    localparam logic [31:0] PRC_BASE  = 32'hffff_e000;
    localparam logic [31:0] PRC_LIMIT = 32'hffff_ffff;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // CON is the only read-only region; everything outside the map is rejected.
    function automatic logic addr_legal(input logic [31:0] addr, input logic we);
        logic ok;
        ok = in_range(addr, CSR_BASE, CSR_LIMIT) ||
             in_range(addr, GPR_BASE, GPR_LIMIT) ||
             in_range(addr, TMP_BASE, TMP_LIMIT) ||
             (addr == RZ_ADDR)                   ||
             in_range(addr, PRC_BASE, PRC_LIMIT);
        if (in_range(addr, CON_BASE, CON_LIMIT))
            ok = !we;
        if (addr[1:0] != 2'b00)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake bundle of the register-store bus arbiter.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 3
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ-1:0][31:0] req_addr;
    logic [NUM_REQ-1:0][31:0] req_wdata;
    logic [NUM_REQ-1:0]       req_ack;
    logic [NUM_REQ-1:0]       req_err;
    logic [31:0]              req_rdata;
    logic [IDX_W-1:0]         grant_id;
    logic                     busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ack, req_err, req_rdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ack, req_err, req_rdata, grant_id, busy
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping to the lowest set request otherwise.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic found;

    always_comb begin
        found   = 1'b0;
        idx_o   = '0;
        gnt_o   = '0;
        valid_o = |req_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                found = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            gnt_o[i] = valid_o && (idx_o == IDX_W'(i));
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared register-store bus: IDLE grant,
// fixed-length ACCESS phase, single-cycle RESP ack back to the winner.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    inout  wire  [31:0]       mem_data
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               sel_we;
    logic [31:0]        sel_addr, sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i];
                sel_wdata = bus.req_wdata[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gid_d   = arb_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    // Rejected accesses skip the bus entirely so mem_addr keeps its last value.
                    if (addr_legal(sel_addr, sel_we)) begin
                        state_d    = ACCESS;
                        err_d      = 1'b0;
                        cnt_d      = CNT_W'(ACCESS_CYCLES - 1);
                        mem_addr_d = sel_addr;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q)
                        rdata_d = mem_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gid_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        bus.req_ack = '0;
        bus.req_err = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_q == RESP) && (gid_q == IDX_W'(i))) begin
                bus.req_ack[i] = 1'b1;
                bus.req_err[i] = err_q;
            end
        end
    end

    assign bus.req_rdata = rdata_q;
    assign bus.grant_id  = gid_q;
    assign bus.busy      = (state_q != IDLE);
    assign mem_we        = (state_q == ACCESS) && we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_we ? wdata_q : 'z;

endmodule
